// File: rtl/spi_resp.sv
// rtl/spi_resp.sv - SPI responder: byte receiver with overrun flag, framed byte transmitter.
// Define SPI_RESP_ECHO_EN to reload the transmit holding register with each received byte.
module spi_resp (
    input  logic       SCLK,
    input  logic       RST,
    input  logic       CS_N,
    input  logic       MOSI,
    output logic       MISO,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_ACK,
    output logic       RX_OVR,
    input  logic [7:0] TX_DATA,
    input  logic       TX_STB,
    output logic       TX_READY,
    output logic       TX_DONE
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    logic [6:0] rx_shift_q, rx_shift_d;
    logic [2:0] rx_cnt_q, rx_cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_ovr_q, rx_ovr_d;
    logic [7:0] rx_byte;
    logic       byte_done;

    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       tx_accept;
    logic       tx_start;

    tx_state_t  state_q, state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_cnt_q, tx_cnt_d;
    logic       miso_q, miso_d;
    logic       tx_done_q, tx_done_d;

    assign rx_byte   = {rx_shift_q, MOSI};
    assign tx_accept = TX_STB & ~hold_full_q;

    // Receive path: completion on the eighth selected edge; an ack on that
    // same edge consumes the old byte, so the new one never counts as overrun.
    always_comb begin
        rx_shift_d = rx_shift_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        byte_done  = 1'b0;
        if (CS_N) begin
            rx_cnt_d = 3'd0;
        end else begin
            rx_shift_d = rx_byte[6:0];
            rx_cnt_d   = rx_cnt_q + 3'd1;
            byte_done  = (rx_cnt_q == 3'd7);
        end
        if (byte_done) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !RX_ACK) begin
                rx_ovr_d = 1'b1;
            end else if (rx_valid_q && RX_ACK) begin
                rx_ovr_d = 1'b0;
            end
        end else if (rx_valid_q && RX_ACK) begin
            rx_valid_d = 1'b0;
            rx_ovr_d   = 1'b0;
        end
    end

    // Transmit FSM: START carries the start bit, DATA the eight data bits.
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        miso_d     = 1'b1;
        tx_done_d  = 1'b0;
        tx_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hold_full_q && !CS_N) begin
                    state_d    = ST_START;
                    miso_d     = 1'b0;
                    tx_shift_d = hold_q;
                    tx_start   = 1'b1;
                end
            end
            ST_START: begin
                if (CS_N) begin
                    state_d    = ST_IDLE;
                    tx_shift_d = 8'h00;
                end else begin
                    state_d    = ST_DATA;
                    miso_d     = tx_shift_q[7];
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    tx_cnt_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (CS_N) begin
                    state_d    = ST_IDLE;
                    tx_shift_d = 8'h00;
                    tx_cnt_d   = 3'd0;
                end else if (tx_cnt_q == 3'd7) begin
                    state_d   = ST_STOP;
                    tx_done_d = 1'b1;
                    tx_cnt_d  = 3'd0;
                end else begin
                    miso_d     = tx_shift_q[7];
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    tx_cnt_d   = tx_cnt_q + 3'd1;
                end
            end
            ST_STOP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register: an explicit strobe always wins over an echoed byte.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (tx_start) begin
            hold_full_d = 1'b0;
        end
        if (tx_accept) begin
            hold_d      = TX_DATA;
            hold_full_d = 1'b1;
        end
`ifdef SPI_RESP_ECHO_EN
        else if (byte_done && !hold_full_q) begin
            hold_d      = rx_byte;
            hold_full_d = 1'b1;
        end
`else
`endif
    end

    always_ff @(posedge SCLK) begin
        if (RST) begin
            rx_shift_q  <= 7'd0;
            rx_cnt_q    <= 3'd0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            state_q     <= ST_IDLE;
            tx_shift_q  <= 8'h00;
            tx_cnt_q    <= 3'd0;
            miso_q      <= 1'b1;
            tx_done_q   <= 1'b0;
        end else begin
            rx_shift_q  <= rx_shift_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovr_q    <= rx_ovr_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            miso_q      <= miso_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign MISO     = miso_q;
    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign RX_OVR   = rx_ovr_q;
    assign TX_READY = ~hold_full_q;
    assign TX_DONE  = tx_done_q;

endmodule

// File: tb/tb_spi_resp.sv
// tb/tb_spi_resp.sv - directed self-checking bench for spi_resp.
`timescale 1ns/1ps
module tb_spi_resp;

    logic       SCLK;
    logic       RST;
    logic       CS_N;
    logic       MOSI;
    logic       MISO;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_ACK;
    logic       RX_OVR;
    logic [7:0] TX_DATA;
    logic       TX_STB;
    logic       TX_READY;
    logic       TX_DONE;

    int checks = 0;
    int errors = 0;

    spi_resp dut (
        .SCLK     (SCLK),
        .RST      (RST),
        .CS_N     (CS_N),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_ACK   (RX_ACK),
        .RX_OVR   (RX_OVR),
        .TX_DATA  (TX_DATA),
        .TX_STB   (TX_STB),
        .TX_READY (TX_READY),
        .TX_DONE  (TX_DONE)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    task automatic step();
        @(posedge SCLK);
        #1;
    endtask

    task automatic do_reset();
        RST    = 1'b1;
        CS_N   = 1'b1;
        MOSI   = 1'b0;
        RX_ACK = 1'b0;
        TX_STB = 1'b0;
        TX_DATA = 8'h00;
        step();
        step();
        RST = 1'b0;
    endtask

    // Sends b[nbits-1:0] MSB first; RX_ACK optionally asserted on the last bit.
    task automatic send_bits(input logic [7:0] b, input int nbits, input logic ack_last);
        for (int i = nbits - 1; i >= 0; i--) begin
            MOSI   = b[i];
            RX_ACK = ack_last && (i == 0);
            step();
        end
        RX_ACK = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; CS_N = 1'b0; MOSI = 1'b1; RX_ACK = 1'b1; TX_STB = 1'b1; TX_DATA = 8'hFF;
        step();
        step();
        checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL reset_miso: got %b expected 1", MISO); end
        checks++; if (RX_DATA !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", RX_DATA); end
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", RX_VALID); end
        checks++; if (RX_OVR !== 1'b0) begin errors++; $display("FAIL reset_rx_ovr: got %b expected 0", RX_OVR); end
        checks++; if (TX_DONE !== 1'b0) begin errors++; $display("FAIL reset_tx_done: got %b expected 0", TX_DONE); end
        checks++; if (TX_READY !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", TX_READY); end
        RST = 1'b0; CS_N = 1'b1; MOSI = 1'b0; RX_ACK = 1'b0; TX_STB = 1'b0;
    endtask

    task automatic test_tx_frame();
        logic [0:9] exp_a5;
        exp_a5 = 10'b0101001011;
        do_reset();
        CS_N = 1'b0;
        TX_DATA = 8'hA5; TX_STB = 1'b1;
        step();
        TX_STB = 1'b0;
        checks++; if (TX_READY !== 1'b0) begin errors++; $display("FAIL a5_ready_after_load: got %b expected 0", TX_READY); end
        checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL a5_idle_at_load: got %b expected 1", MISO); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (MISO !== exp_a5[i]) begin errors++; $display("FAIL a5_miso[%0d]: got %b expected %b", i, MISO, exp_a5[i]); end
            checks++; if (TX_DONE !== (i == 9)) begin errors++; $display("FAIL a5_done[%0d]: got %b expected %b", i, TX_DONE, (i == 9)); end
        end
        step();
        checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL a5_idle_miso: got %b expected 1", MISO); end
        checks++; if (TX_DONE !== 1'b0) begin errors++; $display("FAIL a5_idle_done: got %b expected 0", TX_DONE); end
        CS_N = 1'b1;
    endtask

    task automatic test_rx_overrun();
        do_reset();
        CS_N = 1'b0;
        send_bits(8'h3C >> 1, 7, 1'b0);
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL rx_valid_7bits: got %b expected 0", RX_VALID); end
        send_bits(8'h3C, 1, 1'b0);
        checks++; if (RX_DATA !== 8'h3C) begin errors++; $display("FAIL rx_data_3c: got %h expected 3c", RX_DATA); end
        checks++; if (RX_VALID !== 1'b1) begin errors++; $display("FAIL rx_valid_3c: got %b expected 1", RX_VALID); end
        checks++; if (RX_OVR !== 1'b0) begin errors++; $display("FAIL rx_ovr_3c: got %b expected 0", RX_OVR); end
        send_bits(8'hC3, 8, 1'b0);
        checks++; if (RX_DATA !== 8'hC3) begin errors++; $display("FAIL rx_data_c3: got %h expected c3", RX_DATA); end
        checks++; if (RX_VALID !== 1'b1) begin errors++; $display("FAIL rx_valid_c3: got %b expected 1", RX_VALID); end
        checks++; if (RX_OVR !== 1'b1) begin errors++; $display("FAIL rx_ovr_c3: got %b expected 1", RX_OVR); end
        CS_N = 1'b1; RX_ACK = 1'b1;
        step();
        RX_ACK = 1'b0;
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL rx_ack_valid: got %b expected 0", RX_VALID); end
        checks++; if (RX_OVR !== 1'b0) begin errors++; $display("FAIL rx_ack_ovr: got %b expected 0", RX_OVR); end
        CS_N = 1'b0;
        send_bits(8'h12, 8, 1'b0);
        checks++; if (RX_DATA !== 8'h12) begin errors++; $display("FAIL rx_data_12: got %h expected 12", RX_DATA); end
        send_bits(8'h34, 8, 1'b1);
        checks++; if (RX_DATA !== 8'h34) begin errors++; $display("FAIL rx_data_ack_edge: got %h expected 34", RX_DATA); end
        checks++; if (RX_VALID !== 1'b1) begin errors++; $display("FAIL rx_valid_ack_edge: got %b expected 1", RX_VALID); end
        checks++; if (RX_OVR !== 1'b0) begin errors++; $display("FAIL rx_ovr_ack_edge: got %b expected 0", RX_OVR); end
        CS_N = 1'b1;
        step();
    endtask

    task automatic test_cs_abort();
        do_reset();
        CS_N = 1'b0;
        TX_DATA = 8'h00; TX_STB = 1'b1; MOSI = 1'b1;
        step();
        TX_STB = 1'b0; MOSI = 1'b0;
        step();
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL abort_start_bit: got %b expected 0", MISO); end
        TX_DATA = 8'hC0; TX_STB = 1'b1; MOSI = 1'b1;
        step();
        TX_STB = 1'b0; MOSI = 1'b0;
        step();
        checks++; if (TX_READY !== 1'b0) begin errors++; $display("FAIL abort_reload_ready: got %b expected 0", TX_READY); end
        CS_N = 1'b1;
        step();
        checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL abort_miso: got %b expected 1", MISO); end
        checks++; if (TX_DONE !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", TX_DONE); end
        checks++; if (TX_READY !== 1'b0) begin errors++; $display("FAIL abort_hold_kept: got %b expected 0", TX_READY); end
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL abort_partial_rx: got %b expected 0", RX_VALID); end
        CS_N = 1'b0;
        send_bits(8'h81 >> 7, 1, 1'b0);
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL abort_held_frame_start: got %b expected 0", MISO); end
        send_bits(8'h81 >> 1, 6, 1'b0);
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL abort_rx_7bits: got %b expected 0", RX_VALID); end
        send_bits(8'h81, 1, 1'b0);
        checks++; if (RX_VALID !== 1'b1) begin errors++; $display("FAIL abort_rx_valid: got %b expected 1", RX_VALID); end
        checks++; if (RX_DATA !== 8'h81) begin errors++; $display("FAIL abort_rx_data: got %h expected 81", RX_DATA); end
        CS_N = 1'b1;
        step();
        checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL abort2_miso: got %b expected 1", MISO); end
        checks++; if (TX_DONE !== 1'b0) begin errors++; $display("FAIL abort2_done: got %b expected 0", TX_DONE); end
    endtask

    task automatic test_back_to_back();
        logic [0:22] exp_miso;
        exp_miso = 23'b0_00010001_1_1_0_00100010_1_1_1;
        do_reset();
        CS_N = 1'b0; MOSI = 1'b0;
        TX_DATA = 8'h11; TX_STB = 1'b1;
        step();
        for (int idx = 0; idx < 23; idx++) begin
            TX_STB  = (idx == 1) || (idx == 2);
            TX_DATA = (idx == 1) ? 8'h22 : 8'h33;
            step();
            checks++; if (MISO !== exp_miso[idx]) begin errors++; $display("FAIL b2b_miso[%0d]: got %b expected %b", idx, MISO, exp_miso[idx]); end
            checks++; if (TX_DONE !== ((idx == 9) || (idx == 20))) begin errors++; $display("FAIL b2b_done[%0d]: got %b expected %b", idx, TX_DONE, ((idx == 9) || (idx == 20))); end
            if (idx == 0) begin
                checks++; if (TX_READY !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_start: got %b expected 1", TX_READY); end
            end
            if (idx == 2) begin
                checks++; if (TX_READY !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b expected 0", TX_READY); end
            end
        end
        TX_STB = 1'b0;
        checks++; if (TX_READY !== 1'b1) begin errors++; $display("FAIL b2b_third_ignored: got %b expected 1", TX_READY); end
        CS_N = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        CS_N = 1'b0; MOSI = 1'b1;
        TX_DATA = 8'h00; TX_STB = 1'b1;
        step();
        TX_STB = 1'b0;
        step();
        step();
        step();
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL midrst_pre_miso: got %b expected 0", MISO); end
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL midrst_miso: got %b expected 1", MISO); end
        checks++; if (TX_READY !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", TX_READY); end
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL midrst_rx_valid: got %b expected 0", RX_VALID); end
        checks++; if (TX_DONE !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", TX_DONE); end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL midrst_idle_miso[%0d]: got %b expected 1", i, MISO); end
            checks++; if (TX_DONE !== 1'b0) begin errors++; $display("FAIL midrst_idle_done[%0d]: got %b expected 0", i, TX_DONE); end
        end
        TX_DATA = 8'hFF; TX_STB = 1'b1;
        step();
        TX_STB = 1'b0;
        step();
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL midrst_restart: got %b expected 0", MISO); end
        CS_N = 1'b1;
        step();
    endtask

`ifdef SPI_RESP_ECHO_EN
    task automatic test_echo();
        logic [0:9] exp_5a;
        logic [0:9] exp_77;
        exp_5a = 10'b0010110101;
        exp_77 = 10'b0011101111;
        do_reset();
        CS_N = 1'b0;
        send_bits(8'h5A, 8, 1'b0);
        checks++; if (TX_READY !== 1'b0) begin errors++; $display("FAIL echo_loaded: got %b expected 0", TX_READY); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (MISO !== exp_5a[i]) begin errors++; $display("FAIL echo_miso[%0d]: got %b expected %b", i, MISO, exp_5a[i]); end
        end
        do_reset();
        CS_N = 1'b0;
        send_bits(8'h5A >> 1, 7, 1'b0);
        TX_DATA = 8'h77; TX_STB = 1'b1;
        send_bits(8'h5A, 1, 1'b0);
        TX_STB = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (MISO !== exp_77[i]) begin errors++; $display("FAIL echo_stb_miso[%0d]: got %b expected %b", i, MISO, exp_77[i]); end
        end
        CS_N = 1'b1;
        step();
    endtask
`else
    task automatic test_echo();
        do_reset();
        CS_N = 1'b0;
        send_bits(8'h5A, 8, 1'b0);
        checks++; if (RX_VALID !== 1'b1) begin errors++; $display("FAIL noecho_rx_valid: got %b expected 1", RX_VALID); end
        checks++; if (TX_READY !== 1'b1) begin errors++; $display("FAIL noecho_ready: got %b expected 1", TX_READY); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL noecho_miso[%0d]: got %b expected 1", i, MISO); end
        end
        CS_N = 1'b1;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_tx_frame();
        test_rx_overrun();
        test_cs_abort();
        test_back_to_back();
        test_reset_mid();
        test_echo();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_resp.md
SPI_RESP -- requirements
Module: spi_resp

Interface
REQ-001 SCLK  in  1  serial clock from initiator; all logic on rising edge.
REQ-002 RST  in  1  reset, synchronous, active-high.
REQ-003 CS_N  in  1  select, active-low; frames reception and transmission.
REQ-004 MOSI  in  1  serial data from initiator, MSB first, sampled on rising SCLK.
REQ-005 MISO  out  1  serial data to initiator, registered; idles 1; frame = start bit 0, 8 data bits MSB first, stop bit 1.
REQ-006 RX_DATA  out  8  last received byte.
REQ-007 RX_VALID  out  1  RX_DATA holds an unacknowledged byte; level.
REQ-008 RX_ACK  in  1  consumer acknowledge; clears RX_VALID.
REQ-009 RX_OVR  out  1  sticky overrun flag.
REQ-010 TX_DATA  in  8  byte to transmit.
REQ-011 TX_STB  in  1  load strobe; accepted only when TX_READY=1.
REQ-012 TX_READY  out  1  combinational, = holding register empty.
REQ-013 TX_DONE  out  1  one-cycle pulse during stop-bit cycle.

Function
REQ-014 RX: while CS_N=0, each edge shifts MOSI into rx_shift and increments 3-bit rx_cnt; on rx_cnt=7 edge, RX_DATA <= {rx_shift[6:0],MOSI}, RX_VALID <= 1, rx_cnt wraps to 0.
REQ-015 RX: CS_N=1 clears rx_cnt; partial byte discarded; no RX_VALID change.
REQ-016 RX_ACK=1 with RX_VALID=1 clears RX_VALID and RX_OVR next edge.
REQ-017 Byte completes while RX_VALID=1 and RX_ACK=0: RX_DATA overwritten, RX_VALID stays 1, RX_OVR <= 1.
REQ-018 Byte completes same edge as RX_ACK: new byte loaded, RX_VALID stays 1, RX_OVR not set.
REQ-019 TX_STB=1 and TX_READY=1: TX_DATA into holding register, hold_full <= 1; TX_STB with TX_READY=0 ignored, holding unchanged.
REQ-020 TX FSM states IDLE, START, DATA, STOP.
REQ-021 IDLE: MISO=1; hold_full=1 and CS_N=0 -> START: MISO <= 0, tx_shift <= holding, hold_full <= 0.
REQ-022 START -> DATA: 8 edges, MISO <= tx_shift[7] then shift left; 3-bit tx_cnt counts 0..7.
REQ-023 DATA at tx_cnt=7 -> STOP: MISO <= 1, TX_DONE <= 1; STOP -> IDLE next edge, TX_DONE <= 0.
REQ-024 Latency: TX_STB accepted at edge k (CS_N=0, IDLE) -> MISO=0 after k+1, data bits after k+2..k+9, stop after k+10, IDLE after k+11.
REQ-025 Holding register reloadable from START onward; back-to-back bytes separated by exactly one IDLE cycle.
REQ-026 CS_N=1 in START/DATA/STOP: FSM -> IDLE, MISO <= 1, tx_shift dropped, no TX_DONE; holding register untouched.

Reset
REQ-027 RST=1 at an edge: MISO=1, RX_DATA=0, RX_VALID=0, RX_OVR=0, TX_DONE=0, hold_full=0 (TX_READY=1), FSM=IDLE, rx_cnt=tx_cnt=0; overrides all other inputs.
REQ-028 RST mid-frame: frame aborted, no TX_DONE/RX_VALID; MISO=1 after that edge.

Configuration
REQ-029 Macro SPI_RESP_ECHO_EN defined: on RX byte completion with hold_full=0 and no TX_STB accepted same edge, received byte loads holding register (echo); TX_STB has priority.
REQ-030 SPI_RESP_ECHO_EN undefined: holding register loaded only by TX_STB; RX path never affects TX.

Verification
REQ-031 RST held 2 edges mid-transmit -> MISO=1, TX_READY=1, RX_VALID=0, FSM IDLE.
REQ-032 CS_N=0, TX_STB with 0xA5 -> MISO sequence 0,1,0,1,0,0,1,0,1,1; TX_DONE high only on stop cycle.
REQ-033 CS_N=0, MOSI 0x3C then 0xC3, no RX_ACK -> RX_DATA=0x3C, RX_VALID=1; then RX_DATA=0xC3, RX_OVR=1; RX_ACK clears both flags.
REQ-034 CS_N=1 after 4 MOSI bits, then 8 bits 0x81 -> single RX_VALID, RX_DATA=0x81; TX frame aborted, MISO=1, no TX_DONE.
REQ-035 TX_STB 0x11 then 0x22 during START of first -> both frames sent, one IDLE cycle between; third TX_STB while TX_READY=0 ignored.
REQ-036 SPI_RESP_ECHO_EN defined, MOSI 0x5A, no TX_STB -> MISO frame 0x5A follows; with TX_STB 0x77 same edge -> 0x77 sent.
